// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode constants, ALU control encoding and datapath width
package alu_pkg;
    localparam int WIDTH = 32;
    localparam logic [5:0] OP_ADD  = 6'h20;
    localparam logic [5:0] OP_ADDU = 6'h21;
    localparam logic [5:0] OP_SUB  = 6'h22;
    localparam logic [5:0] OP_SUBU = 6'h23;
    localparam logic [5:0] OP_AND  = 6'h24;
    localparam logic [5:0] OP_OR   = 6'h25;
    localparam logic [5:0] OP_XOR  = 6'h26;
    localparam logic [5:0] OP_NOR  = 6'h27;
    localparam logic [5:0] OP_SLT  = 6'h2A;
    localparam logic [5:0] OP_SLTU = 6'h2B;
    typedef enum logic [3:0] {
        CTL_AND     = 4'b0000,
        CTL_OR      = 4'b0001,
        CTL_ADD     = 4'b0010,
        CTL_XOR     = 4'b0011,
        CTL_SUB     = 4'b0110,
        CTL_SLT     = 4'b0111,
        CTL_SLTU    = 4'b1000,
        CTL_NOR     = 4'b1100,
        CTL_ILLEGAL = 4'b1111
    } alu_ctl_e;
endpackage

// File: rtl/alu_ctl_decode.sv
// alu_ctl_decode: combinational alu_op to alu_ctl table
module alu_ctl_decode
    import alu_pkg::*;
(
    input  logic [5:0] alu_op,
    output alu_ctl_e   alu_ctl
);
    always_comb begin
        alu_ctl = CTL_ILLEGAL;
        case (alu_op)
            OP_AND:          alu_ctl = CTL_AND;
            OP_OR:           alu_ctl = CTL_OR;
            OP_ADD, OP_ADDU: alu_ctl = CTL_ADD;
            OP_XOR:          alu_ctl = CTL_XOR;
            OP_SUB, OP_SUBU: alu_ctl = CTL_SUB;
            OP_SLT:          alu_ctl = CTL_SLT;
            OP_SLTU:         alu_ctl = CTL_SLTU;
            OP_NOR:          alu_ctl = CTL_NOR;
            default:         alu_ctl = CTL_ILLEGAL;
        endcase
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU plus standalone adder, one-cycle registered outputs
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [5:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] add_a,
    input  logic [WIDTH-1:0] add_b,
    output logic [3:0]       alu_ctl,
    output logic [WIDTH-1:0] alu_res,
    output logic             zero,
    output logic             ovf,
    output logic             cout,
    output logic [WIDTH-1:0] sum,
    output logic             illegal,
    output logic             out_valid
);
    localparam int M = WIDTH - 1;
    alu_ctl_e         w_ctl;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_cout;
    logic             w_slt;
    logic             w_sltu;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_zero;
    logic             r_ovf;
    logic             r_cout;
    logic             r_illegal;
    logic             r_valid;

    alu_ctl_decode u_dec (
        .alu_op (alu_op),
        .alu_ctl(w_ctl)
    );

    assign alu_ctl = w_ctl;
    assign w_add   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign w_sub   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    // direct compares stay correct where a-b would overflow
    assign w_slt   = $signed(a) < $signed(b);
    assign w_sltu  = a < b;

    always_comb begin
        w_res  = '0;
        w_ovf  = 1'b0;
        w_cout = 1'b0;
        case (w_ctl)
            CTL_AND:  w_res = a & b;
            CTL_OR:   w_res = a | b;
            CTL_XOR:  w_res = a ^ b;
            CTL_NOR:  w_res = ~(a | b);
            CTL_SLT:  w_res = {{M{1'b0}}, w_slt};
            CTL_SLTU: w_res = {{M{1'b0}}, w_sltu};
            CTL_ADD: begin
                w_res  = w_add[M:0];
                w_cout = w_add[WIDTH];
                w_ovf  = (a[M] == b[M]) && (w_add[M] != a[M]);
            end
            CTL_SUB: begin
                w_res  = w_sub[M:0];
                w_cout = w_sub[WIDTH];
                w_ovf  = (a[M] != b[M]) && (w_sub[M] != a[M]);
            end
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res     <= '0;
            r_sum     <= '0;
            r_zero    <= 1'b1;
            r_ovf     <= 1'b0;
            r_cout    <= 1'b0;
            r_illegal <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_res     <= w_res;
            r_sum     <= add_a + add_b;
            r_zero    <= (w_res == '0);
            r_ovf     <= w_ovf;
            r_cout    <= w_cout;
            r_illegal <= (w_ctl == CTL_ILLEGAL);
            r_valid   <= in_valid;
        end
    end

    assign alu_res   = r_res;
    assign sum       = r_sum;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
    assign cout      = r_cout;
    assign illegal   = r_illegal;
    assign out_valid = r_valid;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed table, hand sequences and randomized checks against a reference model
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [5:0]  alu_op;
    logic [31:0] a, b, add_a, add_b;
    logic        cin;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_res, sum;
    logic        zero, ovf, cout, illegal, out_valid;
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] add_a;
        logic [31:0] add_b;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        cout;
        logic [31:0] sum;
        logic        ill;
        logic [3:0]  ctl;
    } vec_t;

    vec_t tbl[17];
    logic [5:0] ops[10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [31:0] edges[5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

    alu_exec_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .alu_op(alu_op),
        .a(a), .b(b), .cin(cin), .add_a(add_a), .add_b(add_b),
        .alu_ctl(alu_ctl), .alu_res(alu_res), .zero(zero), .ovf(ovf),
        .cout(cout), .sum(sum), .illegal(illegal), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic vec_t model(vec_t v);
        longint unsigned ua = {32'h0, v.a};
        longint unsigned ub = {32'h0, v.b};
        longint sa = longint'($signed(v.a));
        longint sb = longint'($signed(v.b));
        longint unsigned t;
        longint d;
        vec_t r = v;
        r.ovf = 1'b0;
        r.cout = 1'b0;
        r.ill = 1'b0;
        case (v.op)
            6'h20, 6'h21: begin
                t = ua + ub + longint'(v.cin);
                d = sa + sb + longint'(v.cin);
                r.res = t[31:0];
                r.cout = t[32];
                r.ovf = d != longint'($signed(d[31:0]));
                r.ctl = 4'h2;
            end
            6'h22, 6'h23: begin
                t = ua - ub;
                d = sa - sb;
                r.res = t[31:0];
                r.cout = ua >= ub;
                r.ovf = d != longint'($signed(d[31:0]));
                r.ctl = 4'h6;
            end
            6'h24: begin r.res = v.a & v.b; r.ctl = 4'h0; end
            6'h25: begin r.res = v.a | v.b; r.ctl = 4'h1; end
            6'h26: begin r.res = v.a ^ v.b; r.ctl = 4'h3; end
            6'h27: begin r.res = ~(v.a | v.b); r.ctl = 4'hC; end
            6'h2A: begin r.res = (sa < sb) ? 32'd1 : 32'd0; r.ctl = 4'h7; end
            6'h2B: begin r.res = (ua < ub) ? 32'd1 : 32'd0; r.ctl = 4'h8; end
            default: begin r.res = 32'h0; r.ill = 1'b1; r.ctl = 4'hF; end
        endcase
        r.zero = r.res == 32'h0;
        r.sum = v.add_a + v.add_b;
        return r;
    endfunction

    task automatic check_out(string name, vec_t e, logic ev);
        n_vec++;
        if (alu_res !== e.res || zero !== e.zero || ovf !== e.ovf || cout !== e.cout ||
            sum !== e.sum || illegal !== e.ill || out_valid !== ev) begin
            n_err++;
            $display("FAIL %s: got res=%h z=%b ovf=%b c=%b sum=%h ill=%b v=%b, want res=%h z=%b ovf=%b c=%b sum=%h ill=%b v=%b",
                     name, alu_res, zero, ovf, cout, sum, illegal, out_valid,
                     e.res, e.zero, e.ovf, e.cout, e.sum, e.ill, ev);
        end
    endtask

    task automatic drive(vec_t v, logic vld);
        alu_op = v.op; a = v.a; b = v.b; cin = v.cin;
        add_a = v.add_a; add_b = v.add_b; in_valid = vld;
    endtask

    // drive at posedge+1, check alu_ctl immediately, registered outputs at next posedge+1
    task automatic apply(string name, vec_t v, vec_t e, logic vld);
        drive(v, vld);
        #1;
        n_vec++;
        if (alu_ctl !== e.ctl) begin
            n_err++;
            $display("FAIL %s ctl: got %b want %b", name, alu_ctl, e.ctl);
        end
        @(posedge clk);
        #1;
        check_out(name, e, vld);
    endtask

    function automatic vec_t rst_exp();
        vec_t r;
        r = '{6'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0};
        return r;
    endfunction

    initial begin
        vec_t v, e;
        tbl[0]  = '{6'h20, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h00400000, 32'h4, 32'h80000000, 1'b0, 1'b1, 1'b0, 32'h00400004, 1'b0, 4'h2};
        tbl[1]  = '{6'h20, 32'hFFFFFFFF, 32'h1, 1'b0, 32'hFFFFFFFC, 32'h4, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 4'h2};
        tbl[2]  = '{6'h20, 32'h5, 32'h6, 1'b1, 32'h0, 32'h0, 32'hC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h2};
        tbl[3]  = '{6'h21, 32'h5, 32'h6, 1'b0, 32'h10, 32'h20, 32'hB, 1'b0, 1'b0, 1'b0, 32'h30, 1'b0, 4'h2};
        tbl[4]  = '{6'h22, 32'h1234, 32'h1234, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 4'h6};
        tbl[5]  = '{6'h22, 32'h80000000, 32'h1, 1'b0, 32'h0, 32'h0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 4'h6};
        tbl[6]  = '{6'h23, 32'hA, 32'h3, 1'b1, 32'h0, 32'h0, 32'h7, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 4'h6};
        tbl[7]  = '{6'h2A, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h7};
        tbl[8]  = '{6'h2B, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'h8};
        tbl[9]  = '{6'h2A, 32'h7FFFFFFF, 32'h80000000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'h7};
        tbl[10] = '{6'h2A, 32'h80000000, 32'h7FFFFFFF, 1'b0, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h7};
        tbl[11] = '{6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'h0, 32'h0, 32'hF000F000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0};
        tbl[12] = '{6'h25, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'h0, 32'h0, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h1};
        tbl[13] = '{6'h26, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'h0, 32'h0, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h3};
        tbl[14] = '{6'h27, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'h0, 32'h0, 32'h000F000F, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'hC};
        tbl[15] = '{6'h3F, 32'h12345678, 32'h1, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'hF};
        tbl[16] = '{6'h20, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 4'h2};

        reset = 1'b1;
        drive(tbl[2], 1'b1);
        #3;
        check_out("reset_initial", rst_exp(), 1'b0);
        @(posedge clk);
        #1;
        check_out("reset_held", rst_exp(), 1'b0);
        reset = 1'b0;

        foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i], tbl[i], 1'b1);

        // mid-stream reset: an op is captured, the next one is discarded by reset with no edge
        apply("pre_reset", tbl[0], tbl[0], 1'b1);
        drive(tbl[3], 1'b1);
        reset = 1'b1;
        #1;
        check_out("async_reset", rst_exp(), 1'b0);
        @(posedge clk);
        #1;
        check_out("reset_discard", rst_exp(), 1'b0);
        reset = 1'b0;
        apply("post_reset", tbl[3], tbl[3], 1'b1);

        // back-to-back issue, then a bubble with in_valid low
        apply("pipe0", tbl[5], tbl[5], 1'b1);
        apply("pipe1", tbl[7], tbl[7], 1'b1);
        apply("pipe2", tbl[13], tbl[13], 1'b1);
        apply("pipe_bubble", tbl[1], tbl[1], 1'b0);
        apply("pipe3", tbl[2], tbl[2], 1'b1);

        for (int i = 0; i < 400; i++) begin
            v.op    = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            v.a     = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            v.b     = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            v.cin   = 1'($urandom);
            v.add_a = $urandom;
            v.add_b = ($urandom_range(0, 3) == 0) ? 32'h4 : $urandom;
            if ($urandom_range(0, 7) == 0) v.b = v.a;
            e = model(v);
            apply($sformatf("rand%0d", i), v, e, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
